tt_sweep_driver: RTL and testbench

- Upstream stimulus and capture stage for a synthesized 4-input gate netlist.
- Steps the gate's four inputs through all 16 combinations, waits a settle interval per vector, and samples the single gate output.
- Assembles the samples into a 16-bit truth-table word and compares it with the expected table.
- Reports the result to the controller through a start/done handshake.

---
 rtl/tt_sweep_driver.sv | 83 ++++++++
 tb/tb_tt_sweep_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_driver.sv
// tt_sweep_driver: drives a 4-input gate through all 16 vectors, captures its truth table and compares it.
// Define TT_SWEEP_MAJORITY_EN to take a 2-of-3 majority over the last three cycles of each hold window.
module tt_sweep_driver #(
    parameter logic [15:0] EXPECTED_TT = 16'h240F,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  gate_in,
    input  logic        gate_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt_captured,
    output logic [15:0] mismatch,
    output logic        pass
);
    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] idx, idx_nx, cnt, cnt_nx;
    logic [15:0] shreg, shreg_nx;
    logic smp;
`ifdef TT_SWEEP_MAJORITY_EN
    logic [1:0] hist;
    if (SETTLE_CYCLES < 2) begin : g_settle_chk
        $error("SETTLE_CYCLES must be at least 2 for majority sampling");
    end
    always_ff @(posedge clk)
        if (rst) hist <= '0;
        else if (state == HOLD && cnt <= 4'd2) hist <= {hist[0], gate_out};
    assign smp = (hist[1] & hist[0]) | (hist[1] & gate_out) | (hist[0] & gate_out);
`else
    assign smp = gate_out;
`endif
    assign gate_in = state == HOLD ? idx : 4'd0;
    assign busy = state == HOLD;
    assign done = state == DONE;
    // The sample edge doubles as the advance: index, vector and counter all move on it.
    always_comb begin
        state_nx = state;
        idx_nx = idx;
        cnt_nx = cnt;
        shreg_nx = shreg;
        if (state == IDLE && start) begin
            state_nx = HOLD;
            idx_nx = 4'd0;
            cnt_nx = 4'(SETTLE_CYCLES);
            shreg_nx = '0;
        end else if (state == HOLD) begin
            if (cnt != 4'd0) begin
                cnt_nx = cnt - 4'd1;
            end else begin
                shreg_nx[idx] = smp;
                idx_nx = idx + 4'd1;
                cnt_nx = 4'(SETTLE_CYCLES);
                state_nx = idx == 4'd15 ? DONE : HOLD;
            end
        end else if (state == DONE) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            shreg <= '0;
            tt_captured <= '0;
            mismatch <= '0;
            pass <= 1'b0;
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            cnt <= cnt_nx;
            shreg <= shreg_nx;
            if (state == HOLD && state_nx == DONE) begin
                tt_captured <= shreg_nx;
                mismatch <= shreg_nx ^ EXPECTED_TT;
                pass <= shreg_nx == EXPECTED_TT;
            end
        end
    end
endmodule

// File: tb/tb_tt_sweep_driver.sv
// tb_tt_sweep_driver: scoreboard bench for tt_sweep_driver with a settle-2 and a settle-0 instance.
module tb_tt_sweep_driver;
    localparam logic [15:0] EXP = 16'h240F;
`ifdef TT_SWEEP_MAJORITY_EN
    localparam int SC[2] = '{2, 2};
    localparam int WIN = 3;
`else
    localparam int SC[2] = '{2, 0};
    localparam int WIN = 1;
`endif
    typedef struct {int g; logic [15:0] tt;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit rst_q = 1'b0;
    bit fin = 1'b0;
    logic st[2];
    logic gout[2];
    logic [3:0] gin[2];
    logic busy_w[2], done_w[2], pass_w[2];
    logic [15:0] tt_w[2], mm_w[2];
    logic [15:0] tbl[2];
    bit gl_en;
    int gl_idx, gl_off;
    exp_t sb[$];
    int checks = 0, errors = 0;
    int pos[2], was[2];

    always #5 clk = ~clk;

    tt_sweep_driver #(.EXPECTED_TT(EXP), .SETTLE_CYCLES(SC[0])) dut_a (
        .clk(clk), .rst(rst), .start(st[0]), .gate_in(gin[0]), .gate_out(gout[0]),
        .busy(busy_w[0]), .done(done_w[0]), .tt_captured(tt_w[0]), .mismatch(mm_w[0]), .pass(pass_w[0]));
    tt_sweep_driver #(.EXPECTED_TT(EXP), .SETTLE_CYCLES(SC[1])) dut_b (
        .clk(clk), .rst(rst), .start(st[1]), .gate_in(gin[1]), .gate_out(gout[1]),
        .busy(busy_w[1]), .done(done_w[1]), .tt_captured(tt_w[1]), .mismatch(mm_w[1]), .pass(pass_w[1]));

    // Gate model: table lookup, plus an optional one-cycle glitch on dut_a at a given hold offset.
    logic [3:0] pv_in = '0;
    bit pv_busy = 1'b0;
    int pv_off = 0;
    int off_now;
    assign off_now = (pv_busy && busy_w[0] && gin[0] == pv_in) ? pv_off + 1 : 0;
    always @(posedge clk) begin
        pv_in <= gin[0];
        pv_busy <= busy_w[0];
        pv_off <= off_now;
        rst_q <= rst;
    end
    assign gout[0] = tbl[0][gin[0]] ^ (gl_en && int'(gin[0]) == gl_idx && off_now == gl_off);
    assign gout[1] = tbl[1][gin[1]];

    function automatic void chk(string n, int g, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, required %0h", n, g, act, req);
        end
    endfunction

    // Expected capture: majority (or single sample) over the last WIN offsets of each hold window.
    function automatic logic [15:0] model(logic [15:0] t, int s, bit ge, int gi, int go);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            int ones = 0;
            for (int o = s - WIN + 1; o <= s; o++)
                ones += int'(t[i] ^ (ge && i == gi && o == go));
            r[i] = ones * 2 > WIN;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_q) begin
                pos[g] = 0;
                was[g] = 0;
                chk("rst_busy", g, busy_w[g], 0);
                chk("rst_done", g, done_w[g], 0);
                chk("rst_gate_in", g, gin[g], 0);
                chk("rst_tt", g, tt_w[g], 0);
                chk("rst_mismatch", g, mm_w[g], 0);
                chk("rst_pass", g, pass_w[g], 0);
            end else begin
                if (busy_w[g]) begin
                    chk("gate_in_step", g, gin[g], pos[g] / (SC[g] + 1));
                    pos[g]++;
                end else chk("gate_in_idle", g, gin[g], 0);
                if (was[g] != 0 && !busy_w[g]) begin
                    chk("sweep_len", g, pos[g], 16 * (SC[g] + 1));
                    chk("done_after_busy", g, done_w[g], 1);
                    pos[g] = 0;
                end else if (done_w[g]) chk("done_stray", g, 1, 0);
                was[g] = busy_w[g] ? 1 : 0;
                if (done_w[g]) begin
                    if (sb.size() != 0 && sb[0].g == g) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("tt_captured", g, tt_w[g], e.tt);
                        chk("mismatch", g, mm_w[g], e.tt ^ EXP);
                        chk("pass", g, pass_w[g], e.tt == EXP);
                    end else chk("done_unexpected", g, 1, 0);
                end
            end
        end
        if (fin) begin
            chk("scoreboard_empty", 0, sb.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_sweep(int g, logic [15:0] t, bit ge, int gi, int go);
        tbl[g] = t;
        gl_en = ge;
        gl_idx = gi;
        gl_off = go;
        sb.push_back('{g, model(t, SC[g], ge, gi, go)});
        st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
    endtask

    task automatic wait_done(int g);
        int n = 0;
        while (!done_w[g]) begin
            if (++n > 400) begin
                $display("FAIL wait_done dut%0d: got no done, required done within 400 cycles", g);
                $fatal(1, "timeout");
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        st = '{1'b0, 1'b0};
        tbl = '{16'h0, 16'h0};
        gl_en = 1'b0;
        gl_idx = 0;
        gl_off = 0;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        start_sweep(0, EXP, 1'b0, 0, 0);
        wait_done(0);
        start_sweep(0, 16'h242F, 1'b0, 0, 0);
        wait_done(0);
        start_sweep(0, EXP, 1'b0, 0, 0);
        cyc(5);
        st[0] = 1'b1;
        cyc(1);
        st[0] = 1'b0;
        cyc(24);
        st[0] = 1'b1;
        cyc(1);
        st[0] = 1'b0;
        while (!done_w[0]) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        cyc(2);
        start_sweep(0, EXP, 1'b1, 3, 2);
        wait_done(0);
        start_sweep(0, EXP, 1'b0, 0, 0);
        cyc(20);
        void'(sb.pop_back());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        start_sweep(0, EXP, 1'b0, 0, 0);
        wait_done(0);
        for (int k = 0; k < 6; k++) begin
            start_sweep(0, 16'($urandom), 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            wait_done(0);
        end
        start_sweep(1, 16'hFFFF, 1'b0, 0, 0);
        wait_done(1);
        for (int k = 0; k < 3; k++) begin
            start_sweep(1, 16'($urandom), 1'b0, 0, 0);
            wait_done(1);
        end
        cyc(3);
        fin = 1'b1;
    end
endmodule
